// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, tap count and sequencer state encoding for the FIR sequencer.
package fir_pkg;
   localparam int FIR_WIDTH = 18;
   localparam int FIR_TAPS  = 128;
   localparam int FIR_DEPTH = 4;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } fir_state_e;
endpackage

// File: rtl/fir_sfifo.sv
// fir_sfifo: synchronous FIFO with one extra pointer bit to tell full from empty.
module fir_sfifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + 1'b1;
         if (i_pop)  r_rd <= r_rd + 1'b1;
      end
   always_ff @(posedge clk)
      if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
   assign o_data  = r_mem[r_rd[AW-1:0]];
   assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign o_empty = r_wr == r_rd;
endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: buffers samples, drives one TAPS-step burst per sample into the serial
// FIR core, and forwards each captured result (first one after reset dropped) downstream.
module fir_seq_ctrl
   import fir_pkg::*;
#(
   parameter int WIDTH = FIR_WIDTH,
   parameter int TAPS  = FIR_TAPS,
   parameter int DEPTH = FIR_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             s_valid,
   input  logic [WIDTH-1:0] s_data,
   output logic             s_ready,
   output logic [WIDTH-1:0] fir_sample,
   output logic             fir_step,
   input  logic [WIDTH-1:0] fir_result,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data,
   input  logic             m_ready,
   output logic             busy,
   output logic [15:0]      out_cnt
);
   localparam int CW = $clog2(TAPS);
   fir_state_e       r_state;
   fir_state_e       w_next;
   logic [CW-1:0]    r_tap_cnt;
   logic [WIDTH-1:0] r_sample;
   logic [WIDTH-1:0] r_m_data;
   logic [WIDTH-1:0] w_head;
   logic [15:0]      r_out_cnt;
   logic             r_m_valid;
   logic             r_primed;
   logic             w_full;
   logic             w_empty;
   logic             w_last;
   logic             w_start;
   logic             w_cap;
   logic             w_m_hs;
   fir_sfifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .i_push (s_valid && s_ready),
      .i_data (s_data),
      .i_pop  (w_start),
      .o_data (w_head),
      .o_full (w_full),
      .o_empty(w_empty)
   );
   assign s_ready = !rst && !w_full;
   assign w_last  = r_tap_cnt == CW'(TAPS - 1);
   assign w_m_hs  = r_m_valid && m_ready;
   assign w_cap   = (r_state == ST_RUN) && (r_tap_cnt == CW'(1));
   // A new burst may chain straight off the last step so the period is TAPS+1 cycles.
   assign w_start = ((r_state == ST_IDLE) || ((r_state == ST_RUN) && w_last)) &&
                    en && !w_empty && (!r_m_valid || m_ready);
   always_comb begin
      w_next     = w_start ? ST_LOAD :
                   ((r_state == ST_LOAD) || ((r_state == ST_RUN) && !w_last)) ? ST_RUN : ST_IDLE;
      fir_step   = r_state == ST_RUN;
      busy       = r_state != ST_IDLE;
      fir_sample = r_sample;
      m_valid    = r_m_valid;
      m_data     = r_m_data;
      out_cnt    = r_out_cnt;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state   <= ST_IDLE;
         r_tap_cnt <= '0;
         r_sample  <= '0;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_primed  <= 1'b0;
         r_out_cnt <= '0;
      end else begin
         r_state   <= w_next;
         r_tap_cnt <= (r_state == ST_RUN) ? r_tap_cnt + 1'b1 : '0;
         if (w_start) r_sample <= w_head;
         if (w_cap) r_primed <= 1'b1;
         // The core output at the second step belongs to the previous burst's sample.
         if (w_cap && r_primed) begin
            r_m_valid <= 1'b1;
            r_m_data  <= fir_result;
         end else if (w_m_hs) begin
            r_m_valid <= 1'b0;
         end
         if (w_m_hs) r_out_cnt <= r_out_cnt + 1'b1;
      end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: directed bench for the FIR sequencer with a stub core that only
// presents its result at the second step of each burst.
module tb_fir_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        s_valid = 1'b0;
   logic [17:0] s_data = '0;
   logic        s_ready;
   logic [17:0] fir_sample;
   logic        fir_step;
   logic [17:0] fir_result = '0;
   logic        m_valid;
   logic [17:0] m_data;
   logic        m_ready = 1'b0;
   logic        busy;
   logic [15:0] out_cnt;
   logic [17:0] core_res = '0;
   logic [7:0]  stub_k = '0;
   int          n_tests = 0;
   int          n_fail = 0;

   fir_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .fir_sample(fir_sample),
      .fir_step  (fir_step),
      .fir_result(fir_result),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_ready   (m_ready),
      .busy      (busy),
      .out_cnt   (out_cnt)
   );

   always #5 clk = ~clk;

   // Stub core: the real result only at step index 1, junk otherwise.
   always @(negedge clk)
      if (fir_step) begin
         fir_result <= (stub_k == 8'd1) ? core_res : 18'd7;
         stub_k     <= stub_k + 8'd1;
      end else begin
         stub_k <= '0;
      end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [17:0] d);
      int t = 0;
      while (!s_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("push_ready", 32'(s_ready), 1);
      s_valid = 1'b1;
      s_data  = d;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic burst(input logic [17:0] exp, input int drop_at, output time t_load);
      int t = 0;
      int n = 0;
      bit bad = 1'b0;
      while (!(busy && !fir_step) && t < 400) begin
         @(negedge clk);
         t++;
      end
      t_load = $time;
      chk("load", {30'd0, busy, fir_step}, 32'b10);
      chk("sample", 32'(fir_sample), 32'(exp));
      @(negedge clk);
      while (fir_step && n < 400) begin
         if (fir_sample !== exp) bad = 1'b1;
         if (n == drop_at) en = 1'b0;
         n++;
         @(negedge clk);
      end
      chk("steps", n, 128);
      chk("sample_hold", 32'(bad), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      time t0, t1;
      int  acc;
      // 1: reset state, first burst, first result dropped
      repeat (2) @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_step", 32'(fir_step), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_sample", 32'(fir_sample), 0);
      chk("rst_out_cnt", 32'(out_cnt), 0);
      rst = 1'b0;
      en  = 1'b1;
      #1;
      chk("rel_s_ready", 32'(s_ready), 1);
      @(negedge clk);
      push(18'd100);
      burst(18'd100, -1, t0);
      chk("t1_discard", 32'(m_valid), 0);
      // 2: second burst presents the first sample's result
      core_res = 18'd555;
      push(18'd200);
      burst(18'd200, -1, t0);
      chk("t2_m_valid", 32'(m_valid), 1);
      chk("t2_m_data", 32'(m_data), 555);
      chk("t2_out_cnt", 32'(out_cnt), 0);
      // 3: backpressure blocks new bursts; release starts one the same cycle
      for (int i = 0; i < 4; i++) push(18'(300 + 100 * i));
      chk("t3_full", 32'(s_ready), 0);
      chk("t3_blocked", 32'(busy), 0);
      core_res = 18'd2000;
      m_ready  = 1'b1;
      @(negedge clk);
      chk("t3_load_now", {30'd0, busy, fir_step}, 32'b10);
      chk("t3_out_cnt", 32'(out_cnt), 1);
      chk("t3_m_valid", 32'(m_valid), 0);
      for (int i = 0; i < 4; i++) begin
         core_res = 18'(2000 + 1000 * i);
         burst(18'(300 + 100 * i), -1, t1);
         chk("t3_m_data", 32'(m_data), 32'(2000 + 1000 * i));
         chk("t3_cnt", 32'(out_cnt), 32'(2 + i));
         if (i > 0) chk("t3_period", 32'((t1 - t0) / 10), 129);
         t0 = t1;
      end
      // 4: en low, FIFO fills to 4, then drains in order
      en  = 1'b0;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_data  = 18'(11 * (i + 1));
         if (s_ready) acc++;
         @(negedge clk);
      end
      s_valid = 1'b0;
      chk("t4_accepted", acc, 4);
      chk("t4_s_ready", 32'(s_ready), 0);
      chk("t4_idle", 32'(busy), 0);
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         core_res = 18'(6000 + 100 * i);
         burst(18'(11 * (i + 1)), -1, t0);
         chk("t4_m_data", 32'(m_data), 32'(6000 + 100 * i));
      end
      chk("t4_out_cnt", 32'(out_cnt), 9);
      // 5: reset mid-burst
      push(18'd77);
      push(18'd88);
      acc = 0;
      while (!(busy && !fir_step) && acc < 400) begin
         @(negedge clk);
         acc++;
      end
      @(negedge clk);
      for (int n = 0; n < 60 && fir_step; n++) @(negedge clk);
      chk("t5_running", 32'(fir_step), 1);
      rst = 1'b1;
      #1;
      chk("t5_step_drop", 32'(fir_step), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_s_ready", 32'(s_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("t5_fifo_empty", 32'(busy), 0);
      chk("t5_out_cnt", 32'(out_cnt), 0);
      chk("t5_m_valid", 32'(m_valid), 0);
      core_res = 18'd4242;
      push(18'd99);
      burst(18'd99, -1, t0);
      chk("t5_discard", 32'(m_valid), 0);
      m_ready  = 1'b0;
      core_res = 18'd5151;
      push(18'd111);
      burst(18'd111, -1, t0);
      chk("t5_m_valid2", 32'(m_valid), 1);
      chk("t5_m_data", 32'(m_data), 5151);
      // 6: en drop mid-burst, then out_cnt wrap
      m_ready = 1'b1;
      @(negedge clk);
      chk("t6_out_cnt", 32'(out_cnt), 1);
      push(18'd120);
      push(18'd130);
      core_res = 18'd6262;
      burst(18'd120, 10, t0);
      repeat (5) @(negedge clk);
      chk("t6_idle_held", 32'(busy), 0);
      chk("t6_out_cnt2", 32'(out_cnt), 2);
      chk("t6_m_data", 32'(m_data), 6262);
      m_ready = 1'b0;
      force dut.r_out_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.r_out_cnt;
      core_res = 18'd7777;
      en = 1'b1;
      burst(18'd130, -1, t0);
      chk("t6_preload", 32'(out_cnt), 32'hFFFF);
      chk("t6_m_valid", 32'(m_valid), 1);
      chk("t6_m_data2", 32'(m_data), 7777);
      m_ready = 1'b1;
      @(negedge clk);
      chk("t6_wrap", 32'(out_cnt), 0);
      chk("t6_m_clear", 32'(m_valid), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
